// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with a per-register pending-write scoreboard.
// Optional define RF_WR_FWD_EN: clears busy during the final commit and adds the fwd_hit1/fwd_hit2/fwd_data ports.
module rf_wr_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_wr,
    output logic [AW-1:0]        rf_a3,
    output logic [DW-1:0]        rf_wd,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic [AW-1:0]        q_a1,
    input  logic [AW-1:0]        q_a2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 err_underflow
`ifdef RF_WR_FWD_EN
    ,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DW-1:0]        fwd_data
`endif
);

    localparam int NREG = 1 << AW;
    localparam int RRW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [RRW-1:0] rr;
    logic [RRW-1:0] win;
    logic [RRW-1:0] cand;
    logic           xfer;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_data;
    logic [1:0]     cnt [NREG];
    logic           rsv_set;

    // Handshake: a transfer occurs on a rising edge when valid && ready for
    // the same requester; ready may depend on valid, and the requester must
    // hold valid/addr/data stable until it sees ready.
    always_comb begin
        req_ready = '0;
        win       = '0;
        cand      = '0;
        xfer      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = RRW'((int'(rr) + k) % NREQ);
            if (!xfer && req_valid[cand]) begin
                xfer            = 1'b1;
                win             = cand;
                req_ready[cand] = 1'b1;
            end
        end
    end

    assign win_addr = req_addr[win*AW +: AW];
    assign win_data = req_data[win*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr    <= '0;
            rf_wr <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            if (xfer) begin
                rr <= (win == RRW'(NREQ - 1)) ? '0 : win + RRW'(1);
            end
            // Writes to r0 are accepted but never reach the RF.
            rf_wr <= xfer && (win_addr != '0);
            if (xfer && (win_addr != '0)) begin
                rf_a3 <= win_addr;
                rf_wd <= win_data;
            end
        end
    end

    assign rsv_ready = (rsv_addr == '0) || (cnt[rsv_addr] != 2'd3);
    assign rsv_set   = rsv_valid && rsv_ready && (rsv_addr != '0);

    // The registered commit (rf_wr/rf_a3) is what retires a reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (rsv_set && (rsv_addr == AW'(r)) && !(rf_wr && (rf_a3 == AW'(r)))) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (rf_wr && (rf_a3 == AW'(r)) && !(rsv_set && (rsv_addr == AW'(r)))
                             && (cnt[r] != 2'd0)) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
            if (rf_wr && (cnt[rf_a3] == 2'd0) && !(rsv_set && (rsv_addr == rf_a3))) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef RF_WR_FWD_EN
    assign fwd_hit1 = rf_wr && (q_a1 != '0) && (rf_a3 == q_a1) && (cnt[q_a1] == 2'd1);
    assign fwd_hit2 = rf_wr && (q_a2 != '0) && (rf_a3 == q_a2) && (cnt[q_a2] == 2'd1);
    assign fwd_data = rf_wd;
    assign q_busy1  = (q_a1 != '0) && (cnt[q_a1] != 2'd0) && !fwd_hit1;
    assign q_busy2  = (q_a2 != '0) && (cnt[q_a2] != 2'd0) && !fwd_hit2;
`else
    assign q_busy1  = (q_a1 != '0) && (cnt[q_a1] != 2'd0);
    assign q_busy2  = (q_a2 != '0) && (cnt[q_a2] != 2'd0);
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: vector table for arbitration plus hand sequences for
// scoreboard, r0 writes, underflow and mid-stream reset.
module tb_rf_wr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int EW   = 1 + AW + DW;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic                rf_wr;
    logic [AW-1:0]       rf_a3;
    logic [DW-1:0]       rf_wd;
    logic                rsv_valid = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic                rsv_ready;
    logic [AW-1:0]       q_a1 = '0;
    logic [AW-1:0]       q_a2 = '0;
    logic                q_busy1;
    logic                q_busy2;
    logic                err_underflow;
`ifdef RF_WR_FWD_EN
    logic                fwd_hit1;
    logic                fwd_hit2;
    logic [DW-1:0]       fwd_data;
`endif

    always #5 clk = ~clk;

    rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .err_underflow(err_underflow)
`ifdef RF_WR_FWD_EN
        , .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
    );

    typedef struct {
        logic [1:0]    valid;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rsv_v;
        logic [AW-1:0] rsv_a;
        logic [AW-1:0] qa1;
        logic [AW-1:0] qa2;
        logic [1:0]    exp_ready;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    logic          m_wr;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    logic [1:0]    m_cnt[32];
    logic          m_err;
    int            m_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic rsv_v, input logic [AW-1:0] rsv_a,
                                input logic [AW-1:0] qa1, input logic [AW-1:0] qa2,
                                input logic [1:0] exp_ready);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rsv_v = rsv_v; v.rsv_a = rsv_a; v.qa1 = qa1; v.qa2 = qa2;
        v.exp_ready = exp_ready;
        return v;
    endfunction

    function automatic logic [1:0] arb(input logic [1:0] valid, input int rr);
        logic [1:0] g;
        logic       found;
        g = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (rr + k) % NREQ;
            if (!found && valid[i]) begin
                g[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic exp_hit(input logic [AW-1:0] qa);
        return m_wr && (qa != '0) && (m_a3 == qa) && (m_cnt[qa] == 2'd1);
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] qa);
        if (qa == '0) return 1'b0;
`ifdef RF_WR_FWD_EN
        if (exp_hit(qa)) return 1'b0;
`endif
        return m_cnt[qa] != 2'd0;
    endfunction

    task automatic reset_model();
        m_wr = 1'b0; m_a3 = '0; m_wd = '0; m_err = 1'b0; m_rr = 0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 2'd0;
        exp_q.delete();
    endtask

    // One clock cycle: check registered outputs, drive, check combinational outputs, advance the model.
    task automatic cycle(input vec_t v);
        logic [EW-1:0] e;
        logic          exp_rsv;
        logic          set;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {m_wr, m_a3, m_wd} = e;
        end
        chk("rf_wr", rf_wr, m_wr);
        chk("rf_a3", rf_a3, m_a3);
        chk("rf_wd", rf_wd, m_wd);
        chk("err_underflow", err_underflow, m_err);
        req_valid = v.valid;
        req_addr  = {v.a1, v.a0};
        req_data  = {v.d1, v.d0};
        rsv_valid = v.rsv_v;
        rsv_addr  = v.rsv_a;
        q_a1      = v.qa1;
        q_a2      = v.qa2;
        #1;
        chk("req_ready", req_ready, v.exp_ready);
        exp_rsv = (v.rsv_a == '0) || (m_cnt[v.rsv_a] != 2'd3);
        chk("rsv_ready", rsv_ready, exp_rsv);
        chk("q_busy1", q_busy1, exp_busy(v.qa1));
        chk("q_busy2", q_busy2, exp_busy(v.qa2));
`ifdef RF_WR_FWD_EN
        chk("fwd_hit1", fwd_hit1, exp_hit(v.qa1));
        chk("fwd_hit2", fwd_hit2, exp_hit(v.qa2));
        chk("fwd_data", fwd_data, m_wd);
`endif
        set = v.rsv_v && exp_rsv && (v.rsv_a != '0);
        if (m_wr) begin
            if (!(set && (v.rsv_a == m_a3))) begin
                if (m_cnt[m_a3] == 2'd0) m_err = 1'b1;
                else m_cnt[m_a3] = m_cnt[m_a3] - 2'd1;
            end
        end
        if (set && !(m_wr && (v.rsv_a == m_a3))) m_cnt[v.rsv_a] = m_cnt[v.rsv_a] + 2'd1;
        wa = '0;
        wd = '0;
        if (v.exp_ready[0]) begin
            wa = v.a0; wd = v.d0; m_rr = 1 % NREQ;
        end else if (v.exp_ready[1]) begin
            wa = v.a1; wd = v.d1; m_rr = 2 % NREQ;
        end
        if ((v.exp_ready != '0) && (wa != '0)) exp_q.push_back({1'b1, wa, wd});
        else exp_q.push_back({1'b0, m_a3, m_wd});
    endtask

    task automatic hand(input logic [1:0] valid, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic rsv_v, input logic [AW-1:0] rsv_a,
                        input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
        cycle(mk(valid, a0, d0, a1, d1, rsv_v, rsv_a, qa1, qa2, arb(valid, m_rr)));
    endtask

    task automatic idle(input logic [AW-1:0] qa1, input logic [AW-1:0] qa2, input int n);
        for (int i = 0; i < n; i++) hand(2'b00, '0, '0, '0, '0, 1'b0, '0, qa1, qa2);
    endtask

    initial begin
        vecs[0] = mk(2'b00, 5'd5, 32'h11,   5'd6, 32'h22,   1'b1, 5'd5, 5'd5, 5'd6, 2'b00);
        vecs[1] = mk(2'b11, 5'd5, 32'h11,   5'd6, 32'h22,   1'b1, 5'd5, 5'd5, 5'd6, 2'b01);
        vecs[2] = mk(2'b11, 5'd5, 32'h11,   5'd6, 32'h22,   1'b1, 5'd6, 5'd5, 5'd6, 2'b10);
        vecs[3] = mk(2'b11, 5'd5, 32'h11,   5'd6, 32'h22,   1'b1, 5'd6, 5'd5, 5'd6, 2'b01);
        vecs[4] = mk(2'b11, 5'd5, 32'h11,   5'd6, 32'h22,   1'b0, 5'd0, 5'd5, 5'd6, 2'b10);
        vecs[5] = mk(2'b10, 5'd0, 32'h0,    5'd0, 32'hA1,   1'b0, 5'd0, 5'd5, 5'd6, 2'b10);
        vecs[6] = mk(2'b01, 5'd0, 32'hA2,   5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd6, 2'b01);
        vecs[7] = mk(2'b01, 5'd0, 32'hA3,   5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd6, 2'b01);
        vecs[8] = mk(2'b10, 5'd0, 32'h0,    5'd0, 32'hA4,   1'b0, 5'd0, 5'd5, 5'd6, 2'b10);
        vecs[9] = mk(2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd6, 2'b00);

        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rf_wr", rf_wr, 1'b0);
        chk("reset req_ready", req_ready, 2'b00);
        chk("reset q_busy1", q_busy1, 1'b0);
        chk("reset q_busy2", q_busy2, 1'b0);
        chk("reset rsv_ready", rsv_ready, 1'b1);
        chk("reset err_underflow", err_underflow, 1'b0);

        // Alternating grants, back-to-back commits, r0 requests.
        for (int i = 0; i < 10; i++) cycle(vecs[i]);
        idle(5'd5, 5'd6, 2);

        // Four reservations of r7 (fourth refused), then three commits drain it.
        for (int i = 0; i < 4; i++) hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        chk("r7 saturated", m_cnt[7], 2'd3);
        for (int i = 0; i < 3; i++) hand(2'b01, 5'd7, 32'h70 + i, '0, '0, 1'b0, '0, 5'd7, 5'd0);
        idle(5'd7, 5'd0, 3);

        // r9: reserve and commit in the same cycle keep the counter at 1.
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        hand(2'b01, 5'd9, 32'h99, '0, '0, 1'b0, '0, 5'd9, 5'd0);
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0, 1);
        hand(2'b10, '0, '0, 5'd9, 32'h9A, 1'b0, '0, 5'd9, 5'd0);
        idle(5'd9, 5'd0, 2);

        // Write to r0 is swallowed; write to r3 without reservation flags underflow.
        hand(2'b01, 5'd0, 32'hDEAD, '0, '0, 1'b0, '0, 5'd0, 5'd3);
        idle(5'd0, 5'd3, 1);
        hand(2'b10, '0, '0, 5'd3, 32'h33, 1'b0, '0, 5'd0, 5'd3);
        idle(5'd0, 5'd3, 3);

`ifdef RF_WR_FWD_EN
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd4, 5'd0, 5'd4);
        hand(2'b01, 5'd4, 32'h44, '0, '0, 1'b0, '0, 5'd0, 5'd4);
        idle(5'd0, 5'd4, 2);
`endif

        // Mid-stream reset with counters nonzero and a commit in flight.
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd10, 5'd10, 5'd11);
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd10, 5'd10, 5'd11);
        hand(2'b00, '0, '0, '0, '0, 1'b1, 5'd11, 5'd10, 5'd11);
        hand(2'b11, 5'd10, 32'hA0, 5'd11, 32'hB0, 1'b0, '0, 5'd10, 5'd11);
        hand(2'b00, '0, '0, '0, '0, 1'b0, '0, 5'd10, 5'd11);
        rst = 1'b1;
        #1;
        chk("mid-reset rf_wr", rf_wr, 1'b0);
        chk("mid-reset q_busy1", q_busy1, 1'b0);
        chk("mid-reset q_busy2", q_busy2, 1'b0);
        chk("mid-reset err_underflow", err_underflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        hand(2'b11, 5'd12, 32'hC0, 5'd13, 32'hD0, 1'b0, '0, 5'd10, 5'd11);
        chk("post-reset grant r0", req_ready, 2'b01);
        idle(5'd10, 5'd11, 2);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            hand(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(5'd1, 5'd2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Shares the register file's single write port (RFWr/A3/WD) among NREQ writeback requesters, such as the ALU writeback path and the load-data path.
- Grants one request per cycle, round-robin, over valid/ready handshakes.
- Registers the winning write onto the RF port.
- Keeps a per-register pending-write scoreboard, so issue logic can stall read-after-write hazards.
- Sits between the datapath writeback sources and the RF, beside the control FSM.

Parameters:
NREQ, 2, number of write requesters (2..4)
AW, 5, register address width (32 registers)
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  bit i: requester i has a write pending
req_ready  out  NREQ  bit i: requester i granted this cycle
req_addr  in  NREQ*AW  flattened destination addresses; requester i at bits [i*AW +: AW]
req_data  in  NREQ*DW  flattened write data; requester i at bits [i*DW +: DW]
rf_wr  out  1  to RF RFWr
rf_a3  out  AW  to RF A3
rf_wd  out  DW  to RF WD
rsv_valid  in  1  issue stage reserves destination rsv_addr
rsv_addr  in  AW  destination being reserved
rsv_ready  out  1  reservation accepted
q_a1  in  AW  query address 1 (matches RF A1)
q_a2  in  AW  query address 2 (matches RF A2)
q_busy1  out  1  q_a1 has a pending write
q_busy2  out  1  q_a2 has a pending write
err_underflow  out  1  sticky: a write committed to a register with no reservation

Behaviour:
Reset values:
- rf_wr=0, rf_a3=0, rf_wd=0, err_underflow=0.
- All pending counters = 0.
- Round-robin pointer rr=0.
Arbitration (combinational each cycle):
- Scan requesters starting at index rr and wrapping modulo NREQ.
- The first i with req_valid[i]=1 wins; req_ready is one-hot on the winner.
- req_ready=0 everywhere when no request is valid.
- A transfer happens when req_valid[i] && req_ready[i].
- req_ready may depend on req_valid.
- A requester must hold valid, addr and data stable until ready.
Pointer update:
- On a transfer by requester i, rr <= (i+1) mod NREQ.
- Otherwise rr holds.
Write port:
- On a transfer with addr != 0: next cycle rf_wr=1, rf_a3=addr, rf_wd=data. Latency is 1 cycle.
- Throughput is 1 write per cycle, back to back.
- On a transfer with addr == 0: the request is accepted (ready=1) but the next cycle has rf_wr=0.
- rf_a3/rf_wd hold their last value whenever rf_wr=0.
Scoreboard:
- One 2-bit pending counter per register 1..31; register 0 is never busy.
- Set: rsv_valid && rsv_ready && rsv_addr != 0.
- Clear: the registered commit, i.e. rf_wr=1 for rf_a3.
- rsv_ready = 0 when the counter for rsv_addr equals 3; otherwise 1. rsv_ready = 1 for address 0, which is a no-op.
- Set only: counter +1.
- Clear only: counter -1.
- Set and clear on the same register in the same cycle: counter unchanged.
- Clear when the counter is 0: counter stays 0, err_underflow <= 1. It stays set until reset.
Queries:
- q_busyN = (q_aN != 0) && (counter[q_aN] != 0).
- Query outputs are combinational from the registered counters only.
- Without the optional feature, a register is still busy during its own commit cycle.
Reset mid-operation:
- Any in-flight write is discarded; rf_wr is 0 from reset assertion.
- All counters clear.
- Requesters must re-present their requests after reset.

Optional Feature:
Macro RF_WR_FWD_EN.
When defined:
- q_busyN is forced to 0 when rf_wr=1, rf_a3=q_aN and counter[q_aN]=1, i.e. the last pending write is committing this cycle.
- Adds outputs fwd_hit1/fwd_hit2 (1 bit each), asserted under exactly that condition.
- Adds fwd_data (DW), which equals rf_wd.
When undefined:
- Those ports are absent.
- Busy is cleared only in the cycle after the commit.

Test Plan:
- Reset, no stimulus -> rf_wr=0, req_ready=0, q_busy1/2=0, rsv_ready=1, err_underflow=0.
- Both requesters hold valid (r0: addr 5, data 0x11; r1: addr 6, data 0x22) -> grants alternate 0,1,0,1. The cycle after each grant, rf_wr=1 with (5,0x11) then (6,0x22), back to back with no bubble.
- Reserve r7 four times -> first three accepted; fourth sees rsv_ready=0. q_a1=7 gives q_busy1=1; after three commits to r7, q_busy1=0 on the following cycle.
- Reserve r9 while a commit to r9 is in the same cycle, counter 1 before -> counter stays 1 and q_busy stays 1. One more commit -> busy clears.
- Write to r0 with data 0xDEAD -> req_ready=1 and next cycle rf_wr=0. Write to r3 without a reservation -> rf_wr=1 and err_underflow=1 sticky.
- Assert rst mid-stream with counters nonzero and a grant pending -> rf_wr=0 immediately, all q_busy=0, and the next arbitration starts from requester 0. With RF_WR_FWD_EN, a commit to r4 while counter=1 and q_a2=4 -> q_busy2=0, fwd_hit2=1, fwd_data=rf_wd.
